// File: rtl/rc_settle_monitor.sv
// Step-response checker for the RC plant output.
// Measures settle time into a band around TARGET and flags overshoot, timeout and limit violations.
module rc_settle_monitor #(
   parameter real         TARGET      = 1.0,
   parameter real         TOL         = 0.05,
   parameter real         LIMIT       = 2.0,
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned TIMEOUT     = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  real         v_in_i,
   output logic        busy_o,
   output logic        settled_o,
   output logic        timeout_o,
   output logic        overshoot_o,
   output logic [31:0] settle_cycles_o,
   output real         peak_o,
   output logic        bound_err_o
);

   localparam real             BAND_LO   = TARGET - TOL;
   localparam real             BAND_HI   = TARGET + TOL;
   localparam int unsigned     HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [31:0]     CYC_LAST  = 32'(TIMEOUT - 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic            SINGLE    = (HOLD_CYCLES == 1);

   typedef enum logic [2:0] {S_IDLE, S_TRACK, S_HOLD, S_DONE, S_FAIL} state_t;

   state_t        state_q, state_d;
   logic [31:0]   cyc_q, cyc_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [31:0]   sc_q, sc_d;
   real           peak_q, peak_d;
   logic          ovs_q, ovs_d;
   logic          bound_q, bound_d;
   logic          busy_q, busy_d;
   logic          settled_q, settled_d;
   logic          timeout_q, timeout_d;
   logic          in_band;
   logic          streak_done;

   assign in_band     = (v_in_i >= BAND_LO) && (v_in_i <= BAND_HI);
   // This sample is the last one of a full in-band streak.
   assign streak_done = in_band && ((state_q == S_HOLD) ? (hold_q == HOLD_LAST) : SINGLE);

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      hold_d  = hold_q;
      sc_d    = sc_q;
      peak_d  = peak_q;
      ovs_d   = ovs_q;
      bound_d = bound_q | (v_in_i >= LIMIT);

      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start_i) begin
               state_d = S_TRACK;
               cyc_d   = '0;
               hold_d  = '0;
               ovs_d   = 1'b0;
            end
         end
         S_TRACK, S_HOLD: begin
            // The first sample of a run overwrites the previous run's peak.
            if ((cyc_q == '0) || (v_in_i > peak_q)) peak_d = v_in_i;
            if (v_in_i > BAND_HI) ovs_d = 1'b1;
            cyc_d = (cyc_q == CYC_LAST) ? cyc_q : cyc_q + 32'd1;

            if (streak_done) begin
               state_d = S_DONE;
               if (state_q == S_TRACK) sc_d = cyc_q;
            end else if (cyc_q == CYC_LAST) begin
               state_d = S_FAIL;
            end else if (in_band) begin
               if (state_q == S_TRACK) begin
                  state_d = S_HOLD;
                  sc_d    = cyc_q;
                  hold_d  = HW'(1);
               end else begin
                  hold_d  = hold_q + HW'(1);
               end
            end else begin
               state_d = S_TRACK;
               hold_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d == S_TRACK) || (state_d == S_HOLD);
      settled_d = (state_d == S_DONE);
      timeout_d = (state_d == S_FAIL);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cyc_q     <= '0;
         hold_q    <= '0;
         sc_q      <= '0;
         peak_q    <= 0.0;
         ovs_q     <= 1'b0;
         bound_q   <= 1'b0;
         busy_q    <= 1'b0;
         settled_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         hold_q    <= hold_d;
         sc_q      <= sc_d;
         peak_q    <= peak_d;
         ovs_q     <= ovs_d;
         bound_q   <= bound_d;
         busy_q    <= busy_d;
         settled_q <= settled_d;
         timeout_q <= timeout_d;
      end
   end

   assign busy_o          = busy_q;
   assign settled_o       = settled_q;
   assign timeout_o       = timeout_q;
   assign overshoot_o     = ovs_q;
   assign settle_cycles_o = sc_q;
   assign peak_o          = peak_q;
   assign bound_err_o     = bound_q;

endmodule

// File: tb/tb_rc_settle_monitor.sv
// Scoreboard bench for rc_settle_monitor: per-run expectations from a sample-list model.
module tb_rc_settle_monitor;

   localparam real TARGET = 1.0;
   localparam real TOL    = 0.05;
   localparam real LIMIT  = 2.0;
   localparam int  HOLD   = 4;
   localparam int  TMO    = 32;
   localparam real LO     = TARGET - TOL;
   localparam real HI     = TARGET + TOL;

   logic        clk;
   logic        rst;
   logic        start;
   real         v_in;
   logic        busy, settled, timeout, overshoot, bound_err;
   logic [31:0] settle_cycles;
   real         peak;

   rc_settle_monitor #(
      .TARGET(TARGET), .TOL(TOL), .LIMIT(LIMIT),
      .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .v_in_i(v_in),
      .busy_o(busy), .settled_o(settled), .timeout_o(timeout),
      .overshoot_o(overshoot), .settle_cycles_o(settle_cycles),
      .peak_o(peak), .bound_err_o(bound_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chkr(input string name, input real act, input real exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %f expected %f", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic        settled;
      logic        timeout;
      logic        ovs;
      logic [31:0] sc;
      logic [31:0] lat;
   } exp_t;

   exp_t exp_q[$];
   real  peak_exp_q[$];
   real  stim[TMO];
   int   start_at;

   function automatic bit in_band(input real v);
      return (v >= LO) && (v <= HI);
   endfunction

   // Model: scan the run's samples for the first complete in-band streak.
   task automatic run_stim();
      exp_t e;
      int   streak;
      int   last;
      real  pk;
      e      = '0;
      streak = 0;
      last   = TMO - 1;
      for (int i = 0; i < TMO; i++) begin
         streak = in_band(stim[i]) ? streak + 1 : 0;
         if (streak == HOLD) begin
            e.settled = 1'b1;
            e.sc      = 32'(i - HOLD + 1);
            last      = i;
            break;
         end
      end
      e.timeout = !e.settled;
      pk = stim[0];
      for (int i = 0; i <= last; i++) begin
         if (stim[i] > pk) pk = stim[i];
         if (stim[i] > HI) e.ovs = 1'b1;
      end
      e.lat = 32'(last + 1);
      exp_q.push_back(e);
      peak_exp_q.push_back(pk);

      tick();
      start = 1'b1;
      v_in  = 0.0;
      for (int i = 0; i <= last; i++) begin
         tick();
         if (i == 0) begin
            chk1("start_busy", busy, 1'b1);
            chk1("start_clr_settled", settled, 1'b0);
            chk1("start_clr_timeout", timeout, 1'b0);
            chk1("start_clr_overshoot", overshoot, 1'b0);
         end
         start = (i == start_at);
         v_in  = stim[i];
      end
      tick();
      start = 1'b0;
      v_in  = 0.0;
      for (int k = 0; k < 4 && exp_q.size() != 0; k++) tick();
      chk32("run_end_seen", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      peak_exp_q.delete();
   endtask

   // Monitor: a run ends when busy falls; compare against the oldest expectation.
   logic        busy_prev;
   int unsigned busy_cnt;
   exp_t        me;
   real         mpk;

   always @(negedge clk) begin
      if (rst) begin
         busy_prev = 1'b0;
         busy_cnt  = 0;
      end else begin
         if (busy) begin
            busy_cnt++;
         end else if (busy_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_run_end: got end of run expected none");
            end else begin
               me  = exp_q.pop_front();
               mpk = peak_exp_q.pop_front();
               chk1("settled", settled, me.settled);
               chk1("timeout", timeout, me.timeout);
               chk1("overshoot", overshoot, me.ovs);
               chkr("peak", peak, mpk);
               chk32("busy_cycles", 32'(busy_cnt), me.lat);
               if (me.settled) chk32("settle_cycles", settle_cycles, me.sc);
            end
            busy_cnt = 0;
         end
         busy_prev = busy;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      v_in     = 0.0;
      start_at = -1;
      repeat (2) tick();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_settled", settled, 1'b0);
      chk1("rst_timeout", timeout, 1'b0);
      chk1("rst_overshoot", overshoot, 1'b0);
      chk1("rst_bound_err", bound_err, 1'b0);
      chk32("rst_settle_cycles", settle_cycles, 32'd0);
      chkr("rst_peak", peak, 0.0);
      rst = 1'b0;

      // Limit is inclusive: 1.99 leaves bound_err clear, 2.0 sets it in IDLE.
      v_in = 1.99;
      tick();
      chk1("bound_below", bound_err, 1'b0);
      v_in = LIMIT;
      tick();
      v_in = 0.0;
      chk1("bound_set", bound_err, 1'b1);
      chk1("bound_idle_busy", busy, 1'b0);

      // Clean settle.
      for (int i = 0; i < TMO; i++) stim[i] = (i < 5) ? 0.0 : 1.0;
      run_stim();
      chk1("bound_sticky", bound_err, 1'b1);

      // Ringing, with an ignored start mid-run.
      for (int i = 0; i < TMO; i++) stim[i] = 1.02;
      stim[0] = 0.5; stim[1] = 1.2; stim[2] = 0.97; stim[3] = 1.0; stim[4] = 0.9;
      start_at = 2;
      run_stim();
      start_at = -1;

      // Timeout.
      for (int i = 0; i < TMO; i++) stim[i] = 0.5;
      run_stim();

      // Settle completing on the last allowed sample.
      for (int i = 0; i < TMO; i++) stim[i] = (i < 28) ? 0.5 : 1.0;
      run_stim();

      // Exact band edges are in band.
      for (int i = 0; i < TMO; i++) stim[i] = (i % 2 == 0) ? 0.95 : 1.05;
      stim[0] = 0.94;
      run_stim();

      // Randomized runs.
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < TMO; i++) begin
            if ($urandom_range(0, 9) < 6) stim[i] = real'($urandom_range(95, 105)) / 100.0;
            else                          stim[i] = real'($urandom_range(0, 190)) / 100.0;
         end
         start_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
         run_stim();
      end
      start_at = -1;

      // Reset in the middle of a run.
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      v_in  = 0.3;
      tick();
      v_in  = LIMIT;
      tick();
      v_in  = 0.5;
      tick();
      chk1("midrun_busy", busy, 1'b1);
      chk1("midrun_bound", bound_err, 1'b1);
      rst  = 1'b1;
      tick();
      chk1("rstrun_busy", busy, 1'b0);
      chkr("rstrun_peak", peak, 0.0);
      chk1("rstrun_bound", bound_err, 1'b0);
      chk1("rstrun_settled", settled, 1'b0);
      chk1("rstrun_timeout", timeout, 1'b0);
      chk1("rstrun_overshoot", overshoot, 1'b0);
      chk32("rstrun_settle_cycles", settle_cycles, 32'd0);
      rst  = 1'b0;
      v_in = 0.0;

      // Recovery after reset.
      for (int i = 0; i < TMO; i++) stim[i] = (i < 2) ? 1.3 : 1.0;
      run_stim();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rc_settle_monitor.md
# rc_settle_monitor

Downstream checker for the RC plant model. It consumes the model's real-valued `v_out` and, after a `start` pulse, measures how many cycles the output takes to settle inside a tolerance band around a target. It tracks the peak value and flags overshoot, timeout and absolute-limit violations. In the top level it replaces the bare combinational bound assertion with a sequential step-response check that the formal and simulation benches can both observe.

## Interface
- `v_in` real-format parameters: declared with the codebase's real-number declaration macro; format must match the upstream `v_out`.
- `peak` real-format parameters: declared with the same macro; same format as `v_in`.
- `TARGET`, 1.0: settling target (real constant).
- `TOL`, 0.05: half-width of the settle band (real constant, > 0).
- `LIMIT`, 2.0: absolute upper bound on `v_in` (real constant).
- `HOLD_CYCLES`, 8: consecutive in-band samples required to declare settled (integer, ≥ 1).
- `TIMEOUT`, 4096: maximum run length in cycles (integer, > `HOLD_CYCLES`).

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  single-cycle request to begin a measurement.
- `v_in`  input  real  sampled plant output (RC model `v_out`).
- `busy`  output  1  measurement in progress.
- `settled`  output  1  run ended with a successful settle.
- `timeout`  output  1  run ended without settling.
- `overshoot`  output  1  sticky per run; `v_in > TARGET+TOL` seen during the run.
- `settle_cycles`  output  32  run-relative index of the first sample of the final in-band streak.
- `peak`  output  real  maximum `v_in` sampled during the current or last run.
- `bound_err`  output  1  sticky since reset; `v_in >= LIMIT` seen on any cycle.

## Operation
- Band test: `in_band = (v_in >= TARGET-TOL) && (v_in <= TARGET+TOL)`.
  - Built with the codebase's real compare macros.
  - Band edges are computed as real constants at elaboration.
  - Both edges are inclusive.
- FSM states and transitions:
  - IDLE, TRACK, HOLD, DONE, FAIL.
  - IDLE → TRACK on `start`.
  - TRACK → HOLD on `in_band`. That cycle loads `settle_cycles` ← `cyc` and `hold` ← 1.
  - HOLD stays in HOLD while `in_band`, with `hold` incrementing.
  - HOLD → TRACK on `!in_band`, with `hold` ← 0.
  - HOLD → DONE when `in_band` and `hold == HOLD_CYCLES-1` (that sample completes the streak).
  - In TRACK or HOLD, if `cyc == TIMEOUT-1` and no settle completes that cycle → FAIL.
  - DONE or FAIL → TRACK on `start`, which begins a new run.
- Run counter: `cyc` is 32-bit, cleared on the transition into TRACK from any state. It increments each cycle in TRACK/HOLD and saturates at `TIMEOUT-1`.
- `peak`: loaded with `v_in` on the first run cycle, then `peak ← max(peak, v_in)` each TRACK/HOLD cycle. Held in DONE/FAIL/IDLE.
- `overshoot`: cleared on run start, set on any TRACK/HOLD cycle with `v_in > TARGET+TOL`.
- `bound_err`: set on any cycle, in any state, with `v_in >= LIMIT`. Cleared only by `rst`.
- `start` while `busy` is ignored. The run continues unaffected.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - `busy` = 0, `settled` = 0, `timeout` = 0, `overshoot` = 0, `bound_err` = 0.
  - `settle_cycles` = 0, `peak` = 0.0.
- `rst` asserted mid-run returns to IDLE on the next edge with all outputs at reset values. `rst` has priority over `start`.
- Run start:
  - `start` sampled at edge N.
  - `busy` = 1 from N+1.
  - The first `v_in` sample (`cyc` = 0) is taken at edge N+1.
- Settle latency: if `v_in` is in band from sample k onward, `settled` rises one cycle after sample k+HOLD_CYCLES-1, and `busy` falls the same cycle.
- Timeout: `timeout` rises the cycle after sample `TIMEOUT-1`.
- Simultaneous settle completion and `cyc == TIMEOUT-1`: settled wins and `timeout` stays 0.
- `settled`/`timeout` are levels. They hold until the next `start` or `rst`, and clear in the same cycle `busy` rises.

## Test plan
Bench parameters: TARGET 1.0, TOL 0.05, HOLD_CYCLES 4, TIMEOUT 32, LIMIT 2.0.
- Clean settle: `v_in` = 0.0 for 5 samples then 1.0 constant, `start` once → `settled` = 1 after sample 8, `settle_cycles` = 5, `overshoot` = 0, `peak` = 1.0, `timeout` = 0.
- Ringing: sequence 0.5, 1.2, 0.97, 1.0, 0.9, then 1.02 constant → `overshoot` = 1, `peak` = 1.2, `settle_cycles` = 5 (streak broken at 0.9), `settled` after sample 8.
- Timeout: `v_in` = 0.5 constant → `timeout` = 1 the cycle after sample 31, `settled` = 0.
- Timeout tie: `v_in` = 0.5 until sample 27, then 1.0 from sample 28 → the streak completes on sample 31 = TIMEOUT-1 → `settled` = 1, `timeout` = 0, `settle_cycles` = 28.
- Bound and restart: inject `v_in` = 2.0 for one cycle in IDLE → `bound_err` = 1 and stays 1 across a later `start`. `start` during `busy` does not restart `cyc`. `start` in DONE clears `settled` and `overshoot`.
- Reset mid-run: assert `rst` at sample 3 of a run → the next cycle shows IDLE, `busy` = 0, `peak` = 0.0, `bound_err` = 0.
